// File: rtl/opb_register_simulink2ppc_snap_pkg.sv
// Shared constants for the fabric-to-PowerPC snapshot register: register offsets, bit positions, FSM states.
// No logic; imported by the slave controller and the top.
package opb_s2p_pkg;

    localparam logic [7:0] OFF_DATA   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_CTRL   = 8'h08;

    // Big-endian OPB numbering: bit 0 is the MSB of the bus word.
    localparam int BIT_NEW    = 31;
    localparam int BIT_OVF    = 30;
    localparam int BIT_FREEZE = 31;
    localparam int CNT_FIRST  = 0;
    localparam int CNT_LAST   = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_GAP  = 2'd2
    } slv_state_t;

endpackage

// File: rtl/opb_register_simulink2ppc_snap_if.sv
// OPB master/slave signal bundle, big-endian bit numbering as on the bus.
// No latency or flow control of its own; the slave acks with a one-cycle pulse.
interface opb_register_simulink2ppc_snap_if;

    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

endinterface

// File: rtl/opb_register_simulink2ppc_snap_slave_ctrl.sv
// OPB address decode and IDLE/ACK/GAP slave sequencer with latched word offset.
// Ack one cycle after an in-window select; selects in ACK/GAP are ignored (3-cycle spacing).
module opb_slave_ctrl
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0120A300,
    parameter logic [31:0] C_HIGHADDR   = 32'h0120A3FF,
    parameter int          C_OPB_AWIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    select,
    input  logic [0:C_OPB_AWIDTH-1] abus,
    input  logic                    rnw,
    output logic                    accept,
    output logic                    ack,
    output logic                    rd_stb,
    output logic                    wr_stb,
    output logic [7:0]              offset
);

    slv_state_t state_q;
    slv_state_t state_d;
    logic       rnw_q;
    logic       hit;

    assign hit = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rnw_q   <= 1'b0;
            offset  <= 8'h00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rnw_q  <= rnw;
                offset <= {abus[C_OPB_AWIDTH-8:C_OPB_AWIDTH-3], 2'b00};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ack     = 1'b0;
        rd_stb  = 1'b0;
        wr_stb  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    accept  = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                ack     = 1'b1;
                rd_stb  = rnw_q;
                wr_stb  = !rnw_q;
                state_d = ST_GAP;
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// Snapshot register for fabric status words read by the PowerPC: DATA, STATUS (NEW/OVF/CNT), CTRL (FREEZE).
// OPB reads return a snapshot one cycle after select; user_valid is never backpressured, captures drop while frozen.
module opb_register_simulink2ppc_snap
    import opb_s2p_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0120A300,
    parameter logic [31:0] C_HIGHADDR   = 32'h0120A3FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex6"
) (
    input  logic                             OPB_Clk,
    input  logic                             OPB_Rst,
    opb_register_simulink2ppc_snap_if.slave  opb,
    input  logic [31:0]                      user_data_in,
    input  logic                             user_valid
);

    localparam int unused_family_bits = $bits(C_FAMILY);

    logic                    accept;
    logic                    ack;
    logic                    rd_stb;
    logic                    wr_stb;
    logic [7:0]              offset;
    logic [7:0]              cur_off;
    logic [0:C_OPB_DWIDTH-1] rd_mux;
    logic [0:C_OPB_DWIDTH-1] rdata_q;
    logic [31:0]             data_q;
    logic [15:0]             cnt_q;
    logic                    new_q;
    logic                    ovf_q;
    logic                    freeze_q;
    logic                    be_any_q;
    logic                    be3_q;
    logic                    wfreeze_q;
    logic                    capture;
    logic                    data_rd;
    logic                    ctrl_clr;
    logic                    unused_inputs;

    assign unused_inputs = ^{opb.OPB_seqAddr, opb.OPB_DBus[0:30]};

    opb_slave_ctrl #(
        .C_BASEADDR   (C_BASEADDR),
        .C_HIGHADDR   (C_HIGHADDR),
        .C_OPB_AWIDTH (C_OPB_AWIDTH)
    ) u_ctrl (
        .clk    (OPB_Clk),
        .rst    (OPB_Rst),
        .select (opb.OPB_select),
        .abus   (opb.OPB_ABus),
        .rnw    (opb.OPB_RNW),
        .accept (accept),
        .ack    (ack),
        .rd_stb (rd_stb),
        .wr_stb (wr_stb),
        .offset (offset)
    );

    assign cur_off = {opb.OPB_ABus[C_OPB_AWIDTH-8:C_OPB_AWIDTH-3], 2'b00};

    // Read data is muxed from the live address and frozen into rdata_q on accept.
    always_comb begin
        rd_mux = '0;
        case (cur_off)
            OFF_DATA: rd_mux = data_q;
            OFF_STATUS: begin
                rd_mux[CNT_FIRST:CNT_LAST] = cnt_q;
                rd_mux[BIT_OVF]            = ovf_q;
                rd_mux[BIT_NEW]            = new_q;
            end
            OFF_CTRL: rd_mux[BIT_FREEZE] = freeze_q;
            default:  rd_mux = '0;
        endcase
    end

    assign capture  = user_valid && !freeze_q;
    assign data_rd  = rd_stb && (offset == OFF_DATA);
    assign ctrl_clr = wr_stb && (offset == OFF_CTRL) && be_any_q;

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            rdata_q   <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            new_q     <= 1'b0;
            ovf_q     <= 1'b0;
            freeze_q  <= 1'b0;
            be_any_q  <= 1'b0;
            be3_q     <= 1'b0;
            wfreeze_q <= 1'b0;
        end else begin
            if (accept) begin
                rdata_q   <= rd_mux;
                be_any_q  <= |opb.OPB_BE;
                be3_q     <= opb.OPB_BE[3];
                wfreeze_q <= opb.OPB_DBus[BIT_FREEZE];
            end
            if (capture) begin
                data_q <= user_data_in;
                cnt_q  <= cnt_q + 16'd1;
            end
            // A capture landing on a DATA read keeps NEW set and is not an overrun.
            if (capture) begin
                new_q <= 1'b1;
            end else if (data_rd) begin
                new_q <= 1'b0;
            end
            if (ctrl_clr) begin
                ovf_q <= 1'b0;
                cnt_q <= '0;
                if (be3_q) begin
                    freeze_q <= wfreeze_q;
                end
            end else if (capture && new_q && !data_rd) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign opb.Sl_xferAck = ack;
    assign opb.Sl_DBus    = rd_stb ? rdata_q : '0;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Scoreboarded bench: directed scenarios plus random OPB traffic against a register-level model.
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] BASE = 32'h0120A300;
    localparam logic [31:0] HIGH = 32'h0120A3FF;

    typedef struct {
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] user_data_in = '0;
    logic        user_valid = 1'b0;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    logic [31:0] m_data;
    bit          m_new, m_ovf, m_freeze;
    int          m_cnt;

    opb_register_simulink2ppc_snap_if bus();

    opb_register_simulink2ppc_snap dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .opb          (bus),
        .user_data_in (user_data_in),
        .user_valid   (user_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, want);
        end
    endtask

    // Monitor: every cycle the ack and read bus must match what the scoreboard says is due now.
    always @(negedge clk) begin
        bit          want_ack;
        logic [31:0] want_dat;
        want_ack = 1'b0;
        want_dat = '0;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_ack: due cycle %0d, now %0d, got none", sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            want_ack = 1'b1;
            want_dat = sb[0].dat;
            void'(sb.pop_front());
        end
        check("xferAck", {31'b0, bus.Sl_xferAck}, {31'b0, want_ack});
        check("Sl_DBus", bus.Sl_DBus, want_dat);
        check("tied_outputs", {29'b0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'h0);
    end

    function automatic void model_reset();
        m_data = '0; m_new = 0; m_ovf = 0; m_freeze = 0; m_cnt = 0;
    endfunction

    // Numeric view: bus bit 31 is value bit 0, bus bits 0..15 are value bits 31..16.
    function automatic logic [31:0] exp_read(input logic [7:0] off);
        case (off)
            8'h00:   return m_data;
            8'h04:   return (32'(m_cnt) << 16) | (m_ovf ? 32'h2 : 32'h0) | (m_new ? 32'h1 : 32'h0);
            8'h08:   return m_freeze ? 32'h1 : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_cycle(input bit uv, input logic [31:0] ud, input bit ack, input bit rnw,
                                        input logic [7:0] off, input logic [3:0] be, input logic [31:0] wd);
        bit cap, data_rd, ctrl_wr, was_new;
        cap     = uv && !m_freeze;
        data_rd = ack && rnw && off == 8'h00;
        ctrl_wr = ack && !rnw && off == 8'h08 && be != 4'h0;
        was_new = m_new;
        if (data_rd) m_new = 0;
        if (cap) begin
            m_data = ud;
            m_new  = 1;
            m_cnt  = (m_cnt + 1) % 65536;
            if (was_new && !data_rd) m_ovf = 1;
        end
        if (ctrl_wr) begin
            m_cnt = 0;
            m_ovf = 0;
            if (be[0]) m_freeze = wd[0];
        end
    endfunction

    task automatic step(input bit uv, input logic [31:0] ud, input bit ack, input bit rnw,
                        input logic [7:0] off, input logic [3:0] be, input logic [31:0] wd);
        user_valid   = uv;
        user_data_in = ud;
        if (rst) model_reset();
        else     model_cycle(uv, ud, ack, rnw, off, be, wd);
        @(negedge clk);
    endtask

    task automatic idle(input bit uv, input logic [31:0] ud);
        step(uv, ud, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    endtask

    task automatic xfer(input bit rnw, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                        input bit [2:0] uv, input bit gap_sel);
        logic [7:0] off;
        bit         hit;
        off = {addr[7:2], 2'b00};
        hit = (addr >= BASE) && (addr <= HIGH);
        bus.OPB_select = 1'b1;
        bus.OPB_ABus   = addr;
        bus.OPB_RNW    = rnw;
        bus.OPB_BE     = be;
        bus.OPB_DBus   = wd;
        if (hit) sb.push_back('{dat: (rnw ? exp_read(off) : 32'h0), cyc: cyc + 1});
        idle(uv[0], $urandom);
        bus.OPB_select = 1'b0;
        step(uv[1], $urandom, hit, rnw, off, be, wd);
        bus.OPB_select = gap_sel;
        idle(uv[2], $urandom);
        bus.OPB_select = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr);
        xfer(1'b1, addr, 4'hF, 32'h0, 3'b000, 1'b0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        xfer(1'b0, addr, be, wd, 3'b000, 1'b0);
    endtask

    initial begin
        logic [31:0] a, wd_r;
        logic [3:0]  be_r;
        bit          rnw_r;
        bit [2:0]    uv_r;

        bus.OPB_select = 0; bus.OPB_ABus = '0; bus.OPB_BE = '0;
        bus.OPB_DBus = '0;  bus.OPB_RNW = 0;   bus.OPB_seqAddr = 0;
        model_reset();
        @(negedge clk);
        repeat (3) idle(1'b1, $urandom);
        rst = 1'b0;
        idle(1'b0, 32'h0);

        rd(BASE + 32'h4);
        idle(1'b1, 32'hDEADBEEF);
        rd(BASE);
        rd(BASE + 32'h4);

        repeat (3) idle(1'b1, $urandom);
        rd(BASE + 32'h4);
        wr(BASE + 32'h8, 4'b0000, 32'hFFFFFFFF);
        rd(BASE + 32'h4);
        wr(BASE + 32'h8, 4'b0001, 32'h0);
        rd(BASE + 32'h4);
        rd(BASE + 32'h8);

        wr(BASE + 32'h8, 4'b0001, 32'h1);
        repeat (5) idle(1'b1, $urandom);
        rd(BASE);
        rd(BASE + 32'h4);
        rd(BASE + 32'h8);
        wr(BASE + 32'h8, 4'b0001, 32'h0);
        idle(1'b1, 32'h13579BDF);
        rd(BASE);

        // capture in the ACK cycle of a DATA read
        idle(1'b1, 32'hA5A5A5A5);
        wr(BASE + 32'h8, 4'b1000, 32'h0);
        xfer(1'b1, BASE, 4'hF, 32'h0, 3'b010, 1'b0);
        rd(BASE + 32'h4);
        rd(BASE);

        // CTRL write racing a capture
        xfer(1'b0, BASE + 32'h8, 4'b1111, 32'h0, 3'b010, 1'b0);
        rd(BASE + 32'h4);

        wr(BASE + 32'h8, 4'b1111, 32'h0);
        for (int i = 0; i < 65536; i++) idle(1'b1, $urandom);
        rd(BASE + 32'h4);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    a = BASE;
                2, 3:    a = BASE + 32'h4;
                4, 5:    a = BASE + 32'h8;
                6:       a = BASE + 32'($urandom_range(12, 255));
                default: a = BASE + 32'($urandom_range(0, 11));
            endcase
            rnw_r   = ($urandom_range(0, 2) != 0);
            be_r    = 4'($urandom);
            wd_r    = $urandom;
            wd_r[0] = ($urandom_range(0, 3) == 0);
            uv_r    = 3'($urandom);
            xfer(rnw_r, a, be_r, wd_r, uv_r, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) idle($urandom_range(0, 1) == 1, $urandom);
        end

        xfer(1'b1, 32'h0120A400, 4'hF, 32'h0, 3'b000, 1'b1);
        xfer(1'b1, 32'h0120A2FC, 4'hF, 32'h0, 3'b000, 1'b0);
        xfer(1'b0, 32'h0000A308, 4'hF, 32'h1, 3'b000, 1'b0);
        rd(BASE + 32'h8);

        // reset during ACK: the ack already on the bus completes, state clears
        idle(1'b1, 32'h11112222);
        idle(1'b1, 32'h33334444);
        wr(BASE + 32'h8, 4'b0001, 32'h1);
        bus.OPB_select = 1'b1; bus.OPB_ABus = BASE + 32'h4; bus.OPB_RNW = 1'b1;
        sb.push_back('{dat: exp_read(8'h04), cyc: cyc + 1});
        idle(1'b0, 32'h0);
        bus.OPB_select = 1'b0;
        rst = 1'b1;
        idle(1'b1, $urandom);
        rst = 1'b0;
        idle(1'b0, 32'h0);
        rd(BASE);
        rd(BASE + 32'h4);
        rd(BASE + 32'h8);

        // reset coinciding with select: no ack may follow
        bus.OPB_select = 1'b1; bus.OPB_ABus = BASE + 32'h4; bus.OPB_RNW = 1'b1;
        rst = 1'b1;
        idle(1'b1, $urandom);
        bus.OPB_select = 1'b0;
        rst = 1'b0;
        repeat (3) idle(1'b0, 32'h0);
        rd(BASE + 32'h4);

        repeat (4) idle(1'b0, 32'h0);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d acks outstanding, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
